// File: rtl/eulerian_pattern_gen.sv
// Eulerian/gray-code memory test-pattern generator: submit and shift strobes drive counters feeding a registered pattern.
// Optional macro PTRN_INVERT_EN adds the inv_in port, which inverts the whole pattern.
module eulerian_pattern_gen #(
    parameter int unsigned GW        = 5,
    parameter int unsigned DW        = 8,
    parameter int unsigned AW        = 8,
    parameter int unsigned TILE_STEP = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sbmt_in,
    input  logic          shft_in,
    input  logic [1:0]    mode_in,
    input  logic [AW-1:0] addr_in,
`ifdef PTRN_INVERT_EN
    input  logic          inv_in,
`endif
    output logic [DW-1:0] ptrn_out,
    output logic          ptrn_vld,
    output logic          seq_done
);
    localparam int unsigned CW  = $clog2(GW);
    localparam int unsigned DIW = (DW > 1) ? $clog2(DW) : 1;
    localparam int unsigned AIW = (AW > 1) ? $clog2(AW) : 1;
    localparam logic [CW-1:0] LAST = CW'(GW - 1);

    typedef enum logic [1:0] {
        MODE_EULER = 2'd0,
        MODE_SOLID = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_ADDR  = 2'd3
    } mode_e;

    logic [GW-1:0] r_count;
    logic [CW-1:0] r_selcnt;
    logic [CW-1:0] r_tilcnt;

    logic [GW-1:0] w_count_nxt;
    logic [CW-1:0] w_sel_nxt;
    logic [CW-1:0] w_til_nxt;
    logic          w_cnt_wrap;
    logic          w_sel_wrap;
    logic [GW-1:0] w_gray;
    logic [GW-1:0] w_euler;
    int unsigned   w_off;
    logic [DW-1:0] w_ptrn;
    logic [DW-1:0] w_ptrn_fin;

    // Next counter values; the pattern is built from these so it lines up with ptrn_vld.
    always_comb begin
        w_cnt_wrap  = sbmt_in && (r_count == '1);
        w_sel_wrap  = w_cnt_wrap && (r_selcnt == LAST);
        w_count_nxt = r_count + GW'(sbmt_in);
        w_sel_nxt   = r_selcnt;
        if (w_cnt_wrap) begin
            w_sel_nxt = (r_selcnt == LAST) ? '0 : r_selcnt + CW'(1);
        end
        w_til_nxt = r_tilcnt;
        if (shft_in) begin
            w_til_nxt = (r_tilcnt == LAST) ? '0 : r_tilcnt + CW'(1);
        end
    end

    // Gray code rotated by selcnt, with the wrapped-around bit inverted so each sweep is distinct.
    always_comb begin
        w_gray  = w_count_nxt ^ (w_count_nxt >> 1);
        w_euler = w_gray;
        if (w_sel_nxt != '0) begin
            w_euler[0] = ~w_gray[w_sel_nxt];
            for (int unsigned i = 1; i < GW; i++) begin
                if (((i + 32'(w_sel_nxt)) % GW) != 0) begin
                    w_euler[CW'(i)] = w_gray[CW'((i + 32'(w_sel_nxt)) % GW)];
                end else begin
                    w_euler[CW'(i)] = ~w_gray[0];
                end
            end
        end
    end

    always_comb begin
        w_off  = (32'(w_til_nxt) * TILE_STEP) % GW;
        w_ptrn = '0;
        case (mode_e'(mode_in))
            MODE_EULER: begin
                for (int unsigned k = 0; k < DW; k++) begin
                    w_ptrn[DIW'(DW - 1 - k)] = w_euler[CW'((k + w_off) % GW)];
                end
            end
            MODE_SOLID: w_ptrn = '0;
            MODE_CHECK: begin
                for (int unsigned k = 0; k < DW; k++) begin
                    w_ptrn[DIW'(k)] = addr_in[0] ^ k[0];
                end
            end
            MODE_ADDR: begin
                for (int unsigned k = 0; k < DW; k++) begin
                    w_ptrn[DIW'(k)] = addr_in[AIW'(k % AW)];
                end
            end
            default: w_ptrn = '0;
        endcase
    end

`ifdef PTRN_INVERT_EN
    assign w_ptrn_fin = w_ptrn ^ {DW{inv_in}};
`else
    assign w_ptrn_fin = w_ptrn;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count  <= '0;
            r_selcnt <= '0;
            r_tilcnt <= '0;
            ptrn_out <= '0;
            ptrn_vld <= 1'b0;
            seq_done <= 1'b0;
        end else begin
            r_count  <= w_count_nxt;
            r_selcnt <= w_sel_nxt;
            r_tilcnt <= w_til_nxt;
            ptrn_out <= w_ptrn_fin;
            ptrn_vld <= sbmt_in;
            seq_done <= w_sel_wrap;
        end
    end

endmodule

// File: tb/tb_eulerian_pattern_gen.sv
// Directed self-checking bench for eulerian_pattern_gen at default parameters (GW=5, DW=8, AW=8, TILE_STEP=2).
// Inputs are driven on the falling edge and outputs are sampled on the following falling edge.
module tb_eulerian_pattern_gen;
    logic       clk;
    logic       rst;
    logic       sbmt_in;
    logic       shft_in;
    logic [1:0] mode_in;
    logic [7:0] addr_in;
`ifdef PTRN_INVERT_EN
    logic       inv_in;
`endif
    logic [7:0] ptrn_out;
    logic       ptrn_vld;
    logic       seq_done;

    int n_pass;
    int n_chk;

    eulerian_pattern_gen dut (
        .clk      (clk),
        .rst      (rst),
        .sbmt_in  (sbmt_in),
        .shft_in  (shft_in),
        .mode_in  (mode_in),
        .addr_in  (addr_in),
`ifdef PTRN_INVERT_EN
        .inv_in   (inv_in),
`endif
        .ptrn_out (ptrn_out),
        .ptrn_vld (ptrn_vld),
        .seq_done (seq_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0; sbmt_in = 1'b0; shft_in = 1'b0; mode_in = 2'd0; addr_in = 8'h00;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        n_chk++; if (ptrn_out !== 8'h00) $display("FAIL reset_ptrn got %h want 00", ptrn_out); else n_pass++;
        n_chk++; if (ptrn_vld !== 1'b0) $display("FAIL reset_vld got %b want 0", ptrn_vld); else n_pass++;
        n_chk++; if (seq_done !== 1'b0) $display("FAIL reset_done got %b want 0", seq_done); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_mode0_submit();
        apply_reset();
        sbmt_in = 1'b1;
        @(negedge clk); sbmt_in = 1'b0;
        n_chk++; if (ptrn_out !== 8'h84) $display("FAIL submit1_ptrn got %h want 84", ptrn_out); else n_pass++;
        n_chk++; if (ptrn_vld !== 1'b1) $display("FAIL submit1_vld got %b want 1", ptrn_vld); else n_pass++;
        @(negedge clk);
        n_chk++; if (ptrn_vld !== 1'b0) $display("FAIL submit1_vld_drop got %b want 0", ptrn_vld); else n_pass++;
        n_chk++; if (ptrn_out !== 8'h84) $display("FAIL submit1_hold got %h want 84", ptrn_out); else n_pass++;
    endtask

    task automatic test_shift();
        shft_in = 1'b1;
        @(negedge clk); shft_in = 1'b0;
        n_chk++; if (ptrn_out !== 8'h10) $display("FAIL shift1_ptrn got %h want 10", ptrn_out); else n_pass++;
        n_chk++; if (ptrn_vld !== 1'b0) $display("FAIL shift1_vld got %b want 0", ptrn_vld); else n_pass++;
        shft_in = 1'b1;
        @(negedge clk); shft_in = 1'b0;
        n_chk++; if (ptrn_out !== 8'h42) $display("FAIL shift2_ptrn got %h want 42", ptrn_out); else n_pass++;
        shft_in = 1'b1;
        repeat (3) @(negedge clk);
        shft_in = 1'b0;
        n_chk++; if (ptrn_out !== 8'h84) $display("FAIL shift_wrap_ptrn got %h want 84", ptrn_out); else n_pass++;
    endtask

    task automatic test_same_edge();
        apply_reset();
        sbmt_in = 1'b1; shft_in = 1'b1;
        @(negedge clk); sbmt_in = 1'b0; shft_in = 1'b0;
        n_chk++; if (ptrn_out !== 8'h10) $display("FAIL same_edge_ptrn got %h want 10", ptrn_out); else n_pass++;
        n_chk++; if (ptrn_vld !== 1'b1) $display("FAIL same_edge_vld got %b want 1", ptrn_vld); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_p [3];
        exp_p[0] = 8'h84; exp_p[1] = 8'hC6; exp_p[2] = 8'h42;
        apply_reset();
        sbmt_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++; if (ptrn_out !== exp_p[i]) $display("FAIL b2b_ptrn[%0d] got %h want %h", i, ptrn_out, exp_p[i]); else n_pass++;
            n_chk++; if (ptrn_vld !== 1'b1) $display("FAIL b2b_vld[%0d] got %b want 1", i, ptrn_vld); else n_pass++;
        end
        sbmt_in = 1'b0;
        @(negedge clk);
        n_chk++; if (ptrn_vld !== 1'b0) $display("FAIL b2b_vld_end got %b want 0", ptrn_vld); else n_pass++;
    endtask

    task automatic test_mode_change();
        mode_in = 2'd1;
        @(negedge clk);
        n_chk++; if (ptrn_out !== 8'h00) $display("FAIL solid_ptrn got %h want 00", ptrn_out); else n_pass++;
        mode_in = 2'd0;
        @(negedge clk);
        n_chk++; if (ptrn_out !== 8'h42) $display("FAIL mode_back_ptrn got %h want 42", ptrn_out); else n_pass++;
        n_chk++; if (ptrn_vld !== 1'b0) $display("FAIL mode_back_vld got %b want 0", ptrn_vld); else n_pass++;
    endtask

    task automatic test_modes_addr();
        mode_in = 2'd2; addr_in = 8'h00;
        @(negedge clk);
        n_chk++; if (ptrn_out !== 8'hAA) $display("FAIL check0_ptrn got %h want AA", ptrn_out); else n_pass++;
        addr_in = 8'h01;
        @(negedge clk);
        n_chk++; if (ptrn_out !== 8'h55) $display("FAIL check1_ptrn got %h want 55", ptrn_out); else n_pass++;
        mode_in = 2'd3; addr_in = 8'h3C;
        @(negedge clk);
        n_chk++; if (ptrn_out !== 8'h3C) $display("FAIL addr_ptrn got %h want 3C", ptrn_out); else n_pass++;
        mode_in = 2'd0; addr_in = 8'h00;
    endtask

    task automatic test_sweep();
        int n_done;
        int done_at;
        n_done = 0; done_at = 0;
        apply_reset();
        sbmt_in = 1'b1;
        for (int i = 1; i <= 160; i++) begin
            @(negedge clk);
            if (seq_done === 1'b1) begin n_done++; done_at = i; end
            if (i == 32) begin
                n_chk++; if (ptrn_out !== 8'h8C) $display("FAIL sweep32_ptrn got %h want 8C", ptrn_out); else n_pass++;
            end
        end
        sbmt_in = 1'b0;
        n_chk++; if (ptrn_out !== 8'h00) $display("FAIL sweep160_ptrn got %h want 00", ptrn_out); else n_pass++;
        n_chk++; if (n_done != 1 || done_at != 160)
            $display("FAIL sweep_done pulses %0d at submit %0d want 1 at 160", n_done, done_at); else n_pass++;
        @(negedge clk);
        n_chk++; if (seq_done !== 1'b0) $display("FAIL sweep_done_drop got %b want 0", seq_done); else n_pass++;
    endtask

    task automatic test_async_reset();
        apply_reset();
        sbmt_in = 1'b1;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2;
        n_chk++; if (ptrn_out !== 8'h21) $display("FAIL pre_rst_ptrn got %h want 21", ptrn_out); else n_pass++;
        rst = 1'b0;
        #1;
        n_chk++; if (ptrn_out !== 8'h00 || ptrn_vld !== 1'b0 || seq_done !== 1'b0)
            $display("FAIL async_rst got %h/%b/%b want 00/0/0", ptrn_out, ptrn_vld, seq_done); else n_pass++;
        @(posedge clk);
        #1;
        n_chk++; if (ptrn_vld !== 1'b0) $display("FAIL rst_strobe_ignored got %b want 0", ptrn_vld); else n_pass++;
        @(negedge clk);
        sbmt_in = 1'b0; rst = 1'b1;
        @(negedge clk);
        sbmt_in = 1'b1;
        @(negedge clk); sbmt_in = 1'b0;
        n_chk++; if (ptrn_out !== 8'h84) $display("FAIL post_rst_ptrn got %h want 84", ptrn_out); else n_pass++;
    endtask

`ifdef PTRN_INVERT_EN
    task automatic test_invert();
        apply_reset();
        mode_in = 2'd1; inv_in = 1'b1;
        @(negedge clk);
        n_chk++; if (ptrn_out !== 8'hFF) $display("FAIL inv_solid got %h want FF", ptrn_out); else n_pass++;
        mode_in = 2'd0; sbmt_in = 1'b1;
        @(negedge clk); sbmt_in = 1'b0;
        n_chk++; if (ptrn_out !== 8'h7B) $display("FAIL inv_submit got %h want 7B", ptrn_out); else n_pass++;
        inv_in = 1'b0;
    endtask
`endif

    initial begin
        n_pass = 0; n_chk = 0;
        sbmt_in = 1'b0; shft_in = 1'b0; mode_in = 2'd0; addr_in = 8'h00;
`ifdef PTRN_INVERT_EN
        inv_in = 1'b0;
`endif
        test_reset();
        test_mode0_submit();
        test_shift();
        test_same_edge();
        test_back_to_back();
        test_mode_change();
        test_modes_addr();
        test_sweep();
        test_async_reset();
`ifdef PTRN_INVERT_EN
        test_invert();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/eulerian_pattern_gen.md
EULERIAN_PATTERN_GEN -- requirements
Module: eulerian_pattern_gen

Interface
REQ-001 SHALL have parameter GW, default 5, gray/Eulerian counter width (legal 2..8).
REQ-002 SHALL have parameter DW, default 8, pattern data width (legal 1..64).
REQ-003 SHALL have parameter AW, default 8, address width (legal 1..32).
REQ-004 SHALL have parameter TILE_STEP, default 2, tile rotation step (legal 1..GW-1).
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port sbmt_in  input  1  synchronous submit strobe, advances pattern counter.
REQ-008 SHALL have port shft_in  input  1  synchronous shift strobe, advances tile counter.
REQ-009 SHALL have port mode_in  input  2  pattern mode: 0 Eulerian, 1 solid, 2 checkerboard, 3 address.
REQ-010 SHALL have port addr_in  input  AW  current memory address.
REQ-011 SHALL have port ptrn_out  output  DW  registered data pattern.
REQ-012 SHALL have port ptrn_vld  output  1  one-cycle pulse, ptrn_out reflects a submit.
REQ-013 SHALL have port seq_done  output  1  one-cycle pulse, full Eulerian sweep complete.

Function
REQ-014 count (GW bits) SHALL increment by 1 on each clock edge with sbmt_in=1, wrapping 2^GW-1 -> 0.
REQ-015 selcnt SHALL range 0..GW-1, increment only on the edge where count wraps to 0, wrapping GW-1 -> 0.
REQ-016 tilcnt SHALL range 0..GW-1, increment on each edge with shft_in=1, wrapping GW-1 -> 0.
REQ-017 Gray code SHALL be g = count XOR (count >> 1).
REQ-018 For selcnt s=0, e SHALL equal g.
REQ-019 For s>=1: e[0] = ~g[s]; for i>=1, j=(i+s) mod GW, e[i] = g[j] if j!=0 else ~g[0].
REQ-020 Mode 0: with offset o=(tilcnt*TILE_STEP) mod GW, ptrn bit DW-1-k SHALL equal e[(k+o) mod GW].
REQ-021 Mode 1: ptrn SHALL be all zeros.
REQ-022 Mode 2: ptrn bit k SHALL equal addr_in[0] XOR k[0].
REQ-023 Mode 3: ptrn bit k SHALL equal addr_in[k mod AW].
REQ-024 ptrn_out SHALL be registered every clock from current counters/inputs: exactly 1-cycle latency after any counter, mode or address change.
REQ-025 ptrn_vld SHALL assert the cycle after a sbmt_in edge, for one cycle per submit; back-to-back submits give continuous ptrn_vld.
REQ-026 seq_done SHALL pulse one cycle after the edge where selcnt wraps GW-1 -> 0 (every GW*2^GW submits).
REQ-027 sbmt_in and shft_in on the same edge SHALL both take effect on that edge.
REQ-028 mode_in changes SHALL NOT alter any counter.

Reset
REQ-029 rst low SHALL immediately clear count, selcnt, tilcnt, ptrn_out, ptrn_vld, seq_done to 0, independent of clk.
REQ-030 Reset asserted mid-sequence SHALL discard progress; first submit after release yields count=1.
REQ-031 Strobes sampled while rst is low SHALL be ignored.

Configuration
REQ-032 Macro PTRN_INVERT_EN defined: port inv_in (input, 1) SHALL exist; ptrn_out = pattern XOR {DW{inv_in}}, registered with same 1-cycle latency.
REQ-033 PTRN_INVERT_EN undefined: inv_in SHALL be absent and no inversion logic built.

Verification
REQ-034 Reset, mode 0, one submit -> next cycle ptrn_out=8'h84, ptrn_vld=1, then ptrn_vld=0.
REQ-035 Mode 0, one submit, then one shift -> ptrn_out=8'h10 one cycle after shift, ptrn_vld=0.
REQ-036 Mode 0, 32 submits -> count=0, selcnt=1, ptrn_out=8'h8C; 160 submits -> seq_done single pulse, ptrn_out=8'h00.
REQ-037 Mode 2, addr_in=0 then 1 -> ptrn_out=8'hAA then 8'h55; mode 3, addr_in=8'h3C -> ptrn_out=8'h3C.
REQ-038 After 7 submits, rst low mid-cycle -> all outputs 0 asynchronously; release, one submit -> ptrn_out=8'h84.
REQ-039 PTRN_INVERT_EN defined, mode 1, inv_in=1 -> ptrn_out=8'hFF; mode 0, one submit, inv_in=1 -> 8'h7B.
